// File: rtl/minicpu_int_ctrl.sv
// Prioritized 8-source interrupt controller for MiniCPU: mask/priority, Ack/VP vector handshake, EOI.
// Define MINICPU_INT_NEST_EN to let higher-priority sources nest over in-service ones.
module minicpu_int_ctrl #(
  parameter int unsigned N_SRC       = 8,
  parameter logic [15:0] VEC_BASE    = 16'hFFE0,
  parameter logic [15:0] DEFAULT_VEC = 16'hFFFE
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [N_SRC-1:0] IRQ,
  output logic             Int,
  input  logic             Ack,
  input  logic             VP,
  output logic [15:0]      Vector,
  input  logic             Sel,
  input  logic             Rd,
  input  logic             Wr,
  input  logic [1:0]       Addr,
  input  logic [7:0]       DI,
  output logic [7:0]       DO
);

  localparam int unsigned REG_W = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned VEC_W = 16;
  localparam logic [REG_W-1:0] SRC_MASK = REG_W'((32'd1 << N_SRC) - 32'd1);

  localparam logic [1:0] ADDR_IMR = 2'd0;
  localparam logic [1:0] ADDR_IPR = 2'd1;
  localparam logic [1:0] ADDR_ISR = 2'd2;
  localparam logic [1:0] ADDR_ETR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_VWAIT,
    ST_VPULL
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               int_nxt;
  logic [VEC_W-1:0]   vec_nxt;
  logic [IDX_W-1:0]   vec_idx;
  logic [IDX_W-1:0]   vec_idx_nxt;

  logic [REG_W-1:0]   imr;
  logic [REG_W-1:0]   ipr;
  logic [REG_W-1:0]   isr;
  logic [REG_W-1:0]   etr;
  logic [REG_W-1:0]   irq_prev;
  logic [REG_W-1:0]   irq_ext;

  logic [REG_W-1:0]   ipr_nxt;
  logic [REG_W-1:0]   isr_nxt;
  logic [REG_W-1:0]   edge_set;
  logic [REG_W-1:0]   edge_clr;
  logic [REG_W-1:0]   active_mask;
  logic [REG_W-1:0]   eoi_mask;
  logic [REG_W-1:0]   pend_en;
  logic [REG_W-1:0]   rd_data;

  logic               wr_en;
  logic               rd_en;
  logic               wr_imr;
  logic               wr_ipr;
  logic               wr_isr;
  logic               wr_etr;
  logic               ack_take;
  logic               cand_found;
  logic [IDX_W-1:0]   cand_idx;
  logic               eligible;

  function automatic logic [VEC_W-1:0] vec_of(input logic [IDX_W-1:0] idx);
    return VEC_BASE + VEC_W'({idx, 1'b0});
  endfunction

  assign irq_ext  = REG_W'(IRQ);
  assign wr_en    = Sel & Wr;
  assign rd_en    = Sel & Rd;
  assign wr_imr   = wr_en && (Addr == ADDR_IMR);
  assign wr_ipr   = wr_en && (Addr == ADDR_IPR);
  assign wr_isr   = wr_en && (Addr == ADDR_ISR);
  assign wr_etr   = wr_en && (Addr == ADDR_ETR);
  assign ack_take = (state == ST_REQ) && Ack;

  // Acceptance always uses the registered vector index, even if the candidate just vanished.
  assign active_mask = REG_W'(8'd1 << vec_idx);

  // EOI retires the lowest-index (highest-priority) in-service source.
  assign eoi_mask = wr_isr ? (isr & (~isr + REG_W'(1))) : '0;

  assign edge_set = irq_ext & ~irq_prev;
  assign edge_clr = (wr_ipr ? DI : '0) | (ack_take ? active_mask : '0);

  // Edge bits: sticky, a fresh edge beats any clear; level bits: follow the input.
  assign ipr_nxt = ((etr & ((ipr & ~edge_clr) | edge_set)) | (~etr & irq_ext)) & SRC_MASK;
  assign isr_nxt = ((isr & ~eoi_mask) | (ack_take ? active_mask : '0)) & SRC_MASK;

  assign pend_en = ipr & imr;

  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int i = REG_W - 1; i >= 0; i--) begin
      if (pend_en[i]) begin
        cand_found = 1'b1;
        cand_idx   = IDX_W'(i);
      end
    end
  end

`ifdef MINICPU_INT_NEST_EN
  logic [IDX_W-1:0] isr_low_idx;

  always_comb begin
    isr_low_idx = IDX_W'(REG_W - 1);
    for (int i = REG_W - 1; i >= 0; i--) begin
      if (isr[i]) begin
        isr_low_idx = IDX_W'(i);
      end
    end
  end

  assign eligible = cand_found && ((isr == '0) || (cand_idx < isr_low_idx));
`else
  assign eligible = cand_found && (isr == '0);
`endif

  always_comb begin
    rd_data = '0;
    case (Addr)
      ADDR_IMR: rd_data = imr;
      ADDR_IPR: rd_data = ipr;
      ADDR_ISR: rd_data = isr;
      ADDR_ETR: rd_data = etr;
      default:  rd_data = '0;
    endcase
  end

  // Handshake sequencing; Int/Vector are computed here and registered below.
  always_comb begin
    state_nxt   = state;
    int_nxt     = Int;
    vec_nxt     = Vector;
    vec_idx_nxt = vec_idx;
    case (state)
      ST_IDLE: begin
        if (eligible) begin
          state_nxt   = ST_REQ;
          int_nxt     = 1'b1;
          vec_nxt     = vec_of(cand_idx);
          vec_idx_nxt = cand_idx;
        end
      end
      ST_REQ: begin
        if (Ack) begin
          state_nxt = ST_VWAIT;
          int_nxt   = 1'b0;
        end else if (eligible) begin
          vec_nxt     = vec_of(cand_idx);
          vec_idx_nxt = cand_idx;
        end else begin
          state_nxt = ST_IDLE;
          int_nxt   = 1'b0;
          vec_nxt   = DEFAULT_VEC;
        end
      end
      ST_VWAIT: begin
        int_nxt = 1'b0;
        if (VP) begin
          state_nxt = ST_VPULL;
        end
      end
      ST_VPULL: begin
        if (!VP) begin
          state_nxt = ST_IDLE;
          vec_nxt   = DEFAULT_VEC;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        int_nxt   = 1'b0;
        vec_nxt   = DEFAULT_VEC;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= ST_IDLE;
      Int     <= 1'b0;
      Vector  <= DEFAULT_VEC;
      vec_idx <= '0;
    end else begin
      state   <= state_nxt;
      Int     <= int_nxt;
      Vector  <= vec_nxt;
      vec_idx <= vec_idx_nxt;
    end
  end

  // Software-visible registers, edge detector and read-data register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      imr      <= '0;
      ipr      <= '0;
      isr      <= '0;
      etr      <= '0;
      irq_prev <= '0;
      DO       <= '0;
    end else begin
      irq_prev <= irq_ext;
      ipr      <= ipr_nxt;
      isr      <= isr_nxt;
      if (wr_imr) begin
        imr <= DI & SRC_MASK;
      end
      if (wr_etr) begin
        etr <= DI & SRC_MASK;
      end
      if (rd_en) begin
        DO <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_minicpu_int_ctrl.sv
// Scoreboard bench for minicpu_int_ctrl: directed scenarios plus random traffic against a behavioural model.
// Honours MINICPU_INT_NEST_EN the same way as the design.
module tb_minicpu_int_ctrl;

  localparam int NS = 8;
`ifdef MINICPU_INT_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [7:0]  IRQ = '0;
  logic        Int;
  logic        Ack = 1'b0;
  logic        VP = 1'b0;
  logic [15:0] Vector;
  logic        Sel = 1'b0;
  logic        Rd = 1'b0;
  logic        Wr = 1'b0;
  logic [1:0]  Addr = '0;
  logic [7:0]  DI = '0;
  logic [7:0]  DO;

  minicpu_int_ctrl dut (
    .Clk(Clk), .Rst(Rst), .IRQ(IRQ), .Int(Int), .Ack(Ack), .VP(VP),
    .Vector(Vector), .Sel(Sel), .Rd(Rd), .Wr(Wr), .Addr(Addr), .DI(DI), .DO(DO)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: handshake phase 0=idle 1=requesting 2=await pull 3=pulling.
  bit [7:0]    m_imr, m_ipr, m_isr, m_etr, m_prev, m_do;
  int          m_phase, m_vidx;
  bit          m_int;
  logic [15:0] m_vec = 16'hFFFE;

  task automatic model_step();
    bit [7:0] n_ipr, n_isr;
    int cand, low_isr;
    bit elig, took, b;
    if (Rst) begin
      m_imr = 0; m_ipr = 0; m_isr = 0; m_etr = 0; m_prev = 0; m_do = 0;
      m_phase = 0; m_vidx = 0; m_int = 0; m_vec = 16'hFFFE;
      return;
    end
    if (Sel && Rd) begin
      case (Addr)
        2'd0: m_do = m_imr;
        2'd1: m_do = m_ipr;
        2'd2: m_do = m_isr;
        default: m_do = m_etr;
      endcase
    end
    cand = -1;
    for (int i = 0; i < NS; i++) if (cand < 0 && m_ipr[i] && m_imr[i]) cand = i;
    low_isr = NS;
    for (int i = 0; i < NS; i++) if (low_isr == NS && m_isr[i]) low_isr = i;
    elig = (cand >= 0) && (NEST ? (cand < low_isr) : (low_isr == NS));
    took = (m_phase == 1) && Ack;
    for (int i = 0; i < NS; i++) begin
      if (!m_etr[i]) n_ipr[i] = IRQ[i];
      else begin
        b = m_ipr[i];
        if (Sel && Wr && Addr == 2'd1 && DI[i]) b = 0;
        if (took && m_vidx == i) b = 0;
        if (IRQ[i] && !m_prev[i]) b = 1;
        n_ipr[i] = b;
      end
    end
    n_isr = m_isr;
    if (Sel && Wr && Addr == 2'd2 && low_isr < NS) n_isr[low_isr] = 0;
    if (took) n_isr[m_vidx] = 1;
    if (Sel && Wr && Addr == 2'd0) m_imr = DI;
    if (Sel && Wr && Addr == 2'd3) m_etr = DI;
    case (m_phase)
      0: if (elig) begin
           m_phase = 1; m_int = 1; m_vidx = cand; m_vec = 16'hFFE0 + 16'(2 * cand);
         end
      1: if (Ack) begin
           m_phase = 2; m_int = 0;
         end else if (elig) begin
           m_vidx = cand; m_vec = 16'hFFE0 + 16'(2 * cand);
         end else begin
           m_phase = 0; m_int = 0; m_vec = 16'hFFFE;
         end
      2: begin
           m_int = 0;
           if (VP) m_phase = 3;
         end
      default: if (!VP) begin
           m_phase = 0; m_vec = 16'hFFFE;
         end
    endcase
    m_ipr  = n_ipr;
    m_isr  = n_isr;
    m_prev = IRQ;
  endtask

  typedef struct packed {
    logic        i;
    logic [15:0] v;
  } iv_t;

  iv_t        q_iv[$];
  logic [7:0] q_do[$];

  task automatic tick();
    bit  rd;
    iv_t e;
    rd = Sel && Rd;
    model_step();
    @(posedge Clk);
    #1;
    e.i = m_int;
    e.v = m_vec;
    q_iv.push_back(e);
    if (rd) q_do.push_back(m_do);
  endtask

  // Monitor: Int/Vector every cycle, DO whenever a read was issued at the last edge.
  bit  rd_seen = 1'b0;
  iv_t mon_e;
  always @(posedge Clk) rd_seen <= Sel && Rd;
  always @(negedge Clk) begin
    while (q_iv.size() > 0) begin
      mon_e = q_iv.pop_front();
      check("int", 32'(Int), 32'(mon_e.i));
      check("vector", 32'(Vector), 32'(mon_e.v));
    end
    if (rd_seen) begin
      if (q_do.size() == 0) check("do_queue", 32'd0, 32'd1);
      else check("do", 32'(DO), 32'(q_do.pop_front()));
    end
  end

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    Sel = 1; Wr = 1; Addr = a; DI = d;
    tick();
    Sel = 0; Wr = 0;
  endtask

  task automatic rd_reg(input logic [1:0] a, input string nm, input logic [7:0] exp);
    Sel = 1; Rd = 1; Addr = a;
    tick();
    Sel = 0; Rd = 0;
    check(nm, 32'(DO), 32'(exp));
  endtask

  task automatic pull();
    VP = 1; tick(); tick();
    VP = 0; tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset, then level sources with everything masked.
    Rst = 1; IRQ = 8'hFF; tick();
    Rst = 0;
    check("reset_int", 32'(Int), 32'd0);
    check("reset_vec", 32'(Vector), 32'hFFFE);
    tick();
    rd_reg(2'd1, "reset_ipr", 8'hFF);
    rd_reg(2'd0, "reset_imr", 8'h00);
    check("reset_int_masked", 32'(Int), 32'd0);
    IRQ = 0; tick();

    // Edge-triggered source 3, full handshake.
    wr_reg(2'd3, 8'h08);
    wr_reg(2'd0, 8'h08);
    IRQ = 8'h08; tick();
    IRQ = 0;
    check("edge_int_early", 32'(Int), 32'd0);
    tick();
    check("edge_int", 32'(Int), 32'd1);
    check("edge_vec", 32'(Vector), 32'hFFE6);
    Ack = 1; tick(); Ack = 0;
    check("edge_int_acked", 32'(Int), 32'd0);
    VP = 1; tick(); tick();
    check("edge_vec_frozen", 32'(Vector), 32'hFFE6);
    VP = 0; tick();
    check("edge_vec_done", 32'(Vector), 32'hFFFE);
    rd_reg(2'd2, "edge_isr", 8'h08);
    rd_reg(2'd1, "edge_ipr", 8'h00);
    wr_reg(2'd2, 8'h00);
    rd_reg(2'd2, "eoi_isr", 8'h00);

    // Level mode priority replacement while requesting.
    wr_reg(2'd3, 8'h00);
    wr_reg(2'd0, 8'hFF);
    IRQ = 8'h20; tick(); tick();
    check("prio_int", 32'(Int), 32'd1);
    check("prio_vec5", 32'(Vector), 32'hFFEA);
    IRQ = 8'h22; tick();
    check("prio_vec_hold", 32'(Vector), 32'hFFEA);
    tick();
    check("prio_vec1", 32'(Vector), 32'hFFE2);
    Ack = 1; tick(); Ack = 0; IRQ = 0;
    pull();
    rd_reg(2'd2, "prio_isr", 8'h02);
    wr_reg(2'd2, 8'h00);

    // Nesting with source 2 in service.
    IRQ = 8'h04; tick(); tick();
    check("nest_setup_vec", 32'(Vector), 32'hFFE4);
    Ack = 1; tick(); Ack = 0; IRQ = 0;
    pull();
    rd_reg(2'd2, "nest_isr0", 8'h04);
    IRQ = 8'h40;
    repeat (4) tick();
    check("nest_irq6_blocked", 32'(Int), 32'd0);
    IRQ = 8'h41; tick(); tick();
`ifdef MINICPU_INT_NEST_EN
    check("nest_irq0_int", 32'(Int), 32'd1);
    check("nest_irq0_vec", 32'(Vector), 32'hFFE0);
`else
    check("nonest_irq0_int", 32'(Int), 32'd0);
    wr_reg(2'd2, 8'h00);
    tick();
    check("nonest_eoi_int", 32'(Int), 32'd1);
    check("nonest_eoi_vec", 32'(Vector), 32'hFFE0);
`endif
    Ack = 1; tick(); Ack = 0; IRQ = 0;
    pull();
`ifdef MINICPU_INT_NEST_EN
    rd_reg(2'd2, "nest_isr1", 8'h05);
`else
    rd_reg(2'd2, "nest_isr1", 8'h01);
`endif
    wr_reg(2'd2, 8'h00);
    wr_reg(2'd2, 8'h00);
    rd_reg(2'd2, "nest_isr_clear", 8'h00);

    // EOI in the same cycle as Ack.
`ifdef MINICPU_INT_NEST_EN
    IRQ = 8'h10; tick(); tick();
    Ack = 1; tick(); Ack = 0; IRQ = 0;
    pull();
    rd_reg(2'd2, "coll_isr_pre", 8'h10);
`endif
    IRQ = 8'h04; tick(); tick();
    check("coll_vec", 32'(Vector), 32'hFFE4);
    Ack = 1; Sel = 1; Wr = 1; Addr = 2'd2; DI = 8'h00;
    tick();
    Ack = 0; Sel = 0; Wr = 0; IRQ = 0;
    pull();
    rd_reg(2'd2, "coll_isr", 8'h04);
    wr_reg(2'd2, 8'h00);

    // Reset while pulling the vector.
    IRQ = 8'h02; tick(); tick();
    Ack = 1; tick(); Ack = 0;
    VP = 1; tick();
    Rst = 1; tick();
    Rst = 0; VP = 0; IRQ = 0;
    check("rst_int", 32'(Int), 32'd0);
    check("rst_vec", 32'(Vector), 32'hFFFE);
    rd_reg(2'd2, "rst_isr", 8'h00);
    check("rst_idle_int", 32'(Int), 32'd0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      Rst  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) IRQ = IRQ ^ (8'($urandom) & 8'($urandom));
      Ack  = m_int ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      VP   = ($urandom_range(0, 1) == 0);
      Sel  = ($urandom_range(0, 3) == 0);
      Rd   = ($urandom_range(0, 1) == 0);
      Wr   = ($urandom_range(0, 2) == 0);
      Addr = 2'($urandom);
      DI   = 8'($urandom);
      if (Sel && Wr && Addr == 2'd0 && $urandom_range(0, 1) == 0) DI = 8'hFF;
      tick();
    end
    Rst = 0; Ack = 0; VP = 0; Sel = 0; Rd = 0; Wr = 0;
    tick();
    @(negedge Clk);
    @(negedge Clk);
    check("queue_drained", 32'(q_iv.size() + q_do.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
